// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizing, tag encoding and drain-FSM states for the reorder/commit block.
// The register file imports TAG_FREE from here so both sides agree on "no tag".
package rob_commit_ctrl_pkg;

  localparam int DEPTH  = 8;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TAG_W  = PTR_W + 1;
  localparam int CNT_W  = PTR_W + 1;

  // MSB set, index bits zero: never names a real entry.
  localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_st_e;

endpackage

// File: rtl/rob_commit_ctrl_entry_ram.sv
// Per-entry payload storage {reg, data}: one alloc write, one CDB write,
// one asynchronous read at the head. Validity lives in the top-level flags,
// so the arrays need no reset.
module rob_entry_ram
  import rob_commit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              alloc_we,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [REG_W-1:0]  alloc_reg,
  input  logic              cdb_we,
  input  logic [PTR_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data
);

  logic [REG_W-1:0]  reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Destination register is written only at allocation time.
  always_ff @(posedge clk) begin
    if (alloc_we) reg_mem[alloc_idx] <= alloc_reg;
  end

  // Result data is written only by a qualified CDB hit.
  always_ff @(posedge clk) begin
    if (cdb_we) data_mem[cdb_idx] <= cdb_data;
  end

  assign rd_reg  = reg_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer: allocates tags, captures CDB results, retires the
// oldest completed entry per cycle to the register file, and quiesces on drain.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_reg,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_en,
  output logic [REG_W-1:0]  commit_name,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]  busy, done;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  cdb_idx;
  logic              alloc_fire, cdb_hit, commit_fire;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;
  drain_st_e         st, st_nxt;

  assign alloc_ready = (count < CNT_W'(DEPTH)) && (st == RUN);
  assign alloc_tag   = {1'b0, tail};
  assign cdb_idx     = cdb_tag[PTR_W-1:0];

  // Flush cancels everything else happening in the same cycle.
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  // Free/out-of-range tags, idle entries and the slot being allocated are ignored.
  assign cdb_hit     = cdb_valid && !cdb_tag[TAG_W-1] && busy[cdb_idx] && !flush &&
                       !(alloc_fire && (cdb_idx == tail));
  assign commit_fire = busy[head] && done[head] && !flush;

  rob_entry_ram u_ram (
    .clk       (clk),
    .alloc_we  (alloc_fire),
    .alloc_idx (tail),
    .alloc_reg (alloc_reg),
    .cdb_we    (cdb_hit),
    .cdb_idx   (cdb_idx),
    .cdb_data  (cdb_data),
    .rd_idx    (head),
    .rd_reg    (head_reg),
    .rd_data   (head_data)
  );

  // Busy/done flags: completion, then retirement clear, then allocation set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      done <= '0;
    end else if (flush) begin
      busy <= '0;
      done <= '0;
    end else begin
      if (cdb_hit) done[cdb_idx] <= 1'b1;
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
      end
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (commit_fire) head <= head + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered commit write port toward the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_en   <= 1'b0;
      commit_name <= '0;
      commit_data <= '0;
      commit_tag  <= TAG_FREE;
    end else if (commit_fire) begin
      commit_en   <= 1'b1;
      commit_name <= head_reg;
      commit_data <= head_data;
      commit_tag  <= {1'b0, head};
    end else begin
      commit_en   <= 1'b0;
      commit_tag  <= TAG_FREE;
    end
  end

  // Drain FSM state and registered drain_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= RUN;
      drain_done <= 1'b0;
    end else if (flush) begin
      st         <= RUN;
      drain_done <= 1'b0;
    end else begin
      st         <= st_nxt;
      drain_done <= (st_nxt == DONE);
    end
  end

  // Drain next-state: DONE once empty and the last commit write has gone out.
  always_comb begin
    st_nxt = st;
    case (st)
      RUN:     if (drain_req) st_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)                         st_nxt = RUN;
        else if ((count == '0) && !commit_en)   st_nxt = DONE;
      end
      DONE:    if (!drain_req) st_nxt = RUN;
      default: st_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Randomized bench for rob_commit_ctrl against an in-order queue model.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_reg;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              commit_en;
  logic [REG_W-1:0]  commit_name;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic              flush;
  logic              drain_req;
  logic              drain_done;
  logic [CNT_W-1:0]  count;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_en(commit_en), .commit_name(commit_name),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .drain_req(drain_req), .drain_done(drain_done),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: oldest-first list of in-flight instructions plus drain mode.
  typedef struct {
    int          tag;
    int          rg;
    bit          dn;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  int          m_tail;
  int          m_mode;   // 0 running, 1 draining, 2 drained
  bit          m_cen;
  int          m_cname;
  logic [31:0] m_cdata;
  int          m_ctag;
  bit          m_dd;

  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (q.size() < DEPTH) && (m_mode == 0);
  endfunction

  task automatic m_reset();
    q.delete();
    m_tail = 0; m_mode = 0; m_cen = 0; m_cname = 0; m_cdata = '0;
    m_ctag = DEPTH; m_dd = 0;
  endtask

  task automatic check_outs();
    chk("alloc_ready", 64'(alloc_ready), 64'(m_ready()));
    if (m_ready()) chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    chk("count", 64'(count), 64'(q.size()));
    chk("commit_en", 64'(commit_en), 64'(m_cen));
    chk("commit_tag", 64'(commit_tag), 64'(m_ctag));
    chk("drain_done", 64'(drain_done), 64'(m_dd));
    if (m_cen) begin
      chk("commit_name", 64'(commit_name), 64'(m_cname));
      chk("commit_data", 64'(commit_data), 64'(m_cdata));
    end
  endtask

  // One clock edge of behaviour, from the pre-edge model state.
  task automatic m_step(input bit av, input int rg, input bit cv, input int ct,
                        input logic [31:0] cd, input bit fl, input bit dr);
    bit rdy, retire;
    int nm;
    if (fl) begin
      q.delete();
      m_tail = 0; m_mode = 0; m_cen = 0; m_ctag = DEPTH; m_dd = 0;
      return;
    end
    rdy = m_ready();
    nm  = m_mode;
    case (m_mode)
      0: if (dr) nm = 1;
      1: if (!dr) nm = 0; else if (q.size() == 0 && !m_cen) nm = 2;
      default: if (!dr) nm = 0;
    endcase
    retire = (q.size() > 0) && q[0].dn;
    if (retire) begin
      m_cen = 1; m_cname = q[0].rg; m_cdata = q[0].data; m_ctag = q[0].tag;
    end else begin
      m_cen = 0; m_ctag = DEPTH;
    end
    if (cv && ct < DEPTH)
      foreach (q[i]) if (q[i].tag == ct) begin q[i].dn = 1; q[i].data = cd; end
    if (retire) void'(q.pop_front());
    if (av && rdy) begin
      q.push_back('{tag: m_tail, rg: rg, dn: 0, data: '0});
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_mode = nm;
    m_dd   = (nm == 2);
  endtask

  task automatic cyc(input bit av, input int rg, input bit cv, input int ct,
                     input logic [31:0] cd, input bit fl, input bit dr);
    @(negedge clk);
    check_outs();
    alloc_valid = av;
    alloc_reg   = REG_W'(rg);
    cdb_valid   = cv;
    cdb_tag     = TAG_W'(ct);
    cdb_data    = cd;
    flush       = fl;
    drain_req   = dr;
    m_step(av, rg, cv, ct, cd, fl, dr);
  endtask

  task automatic idle(input int n, input bit dr);
    repeat (n) cyc(0, 0, 0, 0, '0, 0, dr);
  endtask

  function automatic int pick_tag();
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      return q[$urandom_range(0, q.size() - 1)].tag;
    return $urandom_range(0, DEPTH);
  endfunction

  initial begin
    bit dr;
    rst = 1'b1;
    alloc_valid = 0; alloc_reg = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    flush = 0; drain_req = 0;
    m_reset();
    @(negedge clk);
    check_outs();
    rst = 1'b0;

    // Out-of-order completion, in-order retirement.
    cyc(1, 3, 0, 0, '0, 0, 0);
    cyc(1, 4, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, 1, 32'hBB, 0, 0);
    cyc(0, 0, 1, 0, 32'hAA, 0, 0);
    idle(4, 0);

    // Fill completely, hold alloc_valid across a same-cycle commit, then wrap.
    for (int i = 0; i < DEPTH; i++) cyc(1, i + 8, 0, 0, '0, 0, 0);
    cyc(1, 20, 1, q[0].tag, 32'h5555_0000, 0, 0);
    cyc(1, 21, 0, 0, '0, 0, 0);
    cyc(1, 22, 0, 0, '0, 0, 0);
    repeat (24) cyc(0, 0, q.size() > 0, q.size() > 0 ? q[0].tag : 0, $urandom, 0, 0);

    // Free tag and an idle entry on the CDB.
    cyc(0, 0, 1, DEPTH, 32'hDEAD, 0, 0);
    cyc(0, 0, 1, 5, 32'hBEEF, 0, 0);
    idle(2, 0);

    // Flush with results in flight and a same-cycle CDB.
    cyc(1, 1, 0, 0, '0, 0, 0);
    cyc(1, 2, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, q[1].tag, 32'h11, 0, 0);
    cyc(0, 0, 1, q[2].tag, 32'h22, 0, 0);
    cyc(0, 0, 1, q[0].tag, 32'h33, 1, 0);
    idle(3, 0);
    cyc(1, 6, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, 0, 32'h66, 0, 0);
    idle(3, 0);

    // Drain with two pending entries.
    cyc(1, 7, 0, 0, '0, 0, 0);
    cyc(1, 8, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, 0, '0, 0, 1);
    cyc(1, 9, 1, q[0].tag, 32'h77, 0, 1);
    cyc(0, 0, 1, q[1].tag, 32'h88, 0, 1);
    idle(6, 1);
    idle(3, 0);

    // Random traffic.
    dr = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) dr = ~dr;
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 31),
          $urandom_range(0, 1), pick_tag(), $urandom,
          $urandom_range(0, 49) == 0, dr);
    end

    // Asynchronous reset while a commit is on the port.
    cyc(0, 0, 0, 0, '0, 1, 0);
    cyc(1, 9, 0, 0, '0, 0, 0);
    cyc(1, 10, 0, 0, '0, 0, 0);
    cyc(1, 11, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, 0, 32'h1234, 0, 0);
    cyc(0, 0, 0, 0, '0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_commit_en", 64'(commit_en), 64'(m_cen));
    rst = 1'b1;
    #1;
    chk("rst_commit_en", 64'(commit_en), 64'd0);
    chk("rst_commit_tag", 64'(commit_tag), 64'(DEPTH));
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    m_reset();
    @(negedge clk);
    check_outs();
    rst = 1'b0;
    cyc(1, 12, 0, 0, '0, 0, 0);
    idle(2, 0);
    @(negedge clk);
    check_outs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
